// File: rtl/irst_ctrl_pkg.sv
// Shared definitions for the instruction-reset control unit: register map,
// FSM encoding and the layout of the word driven to the fetch stage.
package irst_ctrl_pkg;

  localparam logic [1:0] IRST_CFG    = 2'd0;
  localparam logic [1:0] IRST_PERIOD = 2'd1;
  localparam logic [1:0] IRST_CMD    = 2'd2;
  localparam logic [1:0] IRST_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } irst_state_e;

  // irst_reg_data field positions, shared with the fetch stage
  localparam int IRST_EN_BIT     = 15;
  localparam int IRST_PCL_HI     = 14;
  localparam int IRST_PCL_LO     = 8;
  localparam int IRST_MIS_HI     = 5;
  localparam int IRST_MIS_LO     = 0;

  // CFG register image, bits [14:0]
  typedef struct packed {
    logic [6:0] pc_limit;
    logic       irq_en;
    logic       periodic;
    logic [5:0] mis_count;
  } irst_cfg_t;

  function automatic logic [15:0] irst_pack(input logic en, input logic [6:0] pc,
                                            input logic [5:0] mis);
    return {en, pc, 2'b00, mis};
  endfunction

endpackage

// File: rtl/irst_regfile.sv
// Software-visible registers: CFG and PERIOD storage, CMD decode into
// start/abort pulses, and the combinational read mux.
module irst_regfile
  import irst_ctrl_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wr_en_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [15:0]         cfg_wr_data_i,
  output logic [15:0]         cfg_rd_data_o,
  input  logic [7:0]          run_count_i,
  input  logic                abort_pend_i,
  input  irst_state_e         state_i,
  output irst_cfg_t           cfg_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                start_o,
  output logic                abort_o
);

  irst_cfg_t           cfg_q;
  logic [PERIOD_W-1:0] period_q;
  logic                cmd_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= '0;
      period_q <= '0;
    end else if (cfg_wr_en_i) begin
      if (cfg_addr_i == IRST_CFG)    cfg_q    <= irst_cfg_t'(cfg_wr_data_i[14:0]);
      if (cfg_addr_i == IRST_PERIOD) period_q <= PERIOD_W'(cfg_wr_data_i);
    end
  end

  // Abort dominates a simultaneous start.
  assign cmd_wr  = cfg_wr_en_i && (cfg_addr_i == IRST_CMD);
  assign abort_o = cmd_wr && cfg_wr_data_i[1];
  assign start_o = cmd_wr && cfg_wr_data_i[0] && !cfg_wr_data_i[1];

  always_comb begin
    cfg_rd_data_o = '0;
    case (cfg_addr_i)
      IRST_CFG:    cfg_rd_data_o = {1'b0, cfg_q};
      IRST_PERIOD: cfg_rd_data_o = 16'(period_q);
      IRST_STATUS: cfg_rd_data_o = {run_count_i, 5'b0, abort_pend_i, state_i};
      default:     cfg_rd_data_o = '0;
    endcase
  end

  assign cfg_o    = cfg_q;
  assign period_o = period_q;

endmodule

// File: rtl/irst_ctrl.sv
// Instruction-reset sequencer: launches single/periodic runs toward the fetch
// stage, waits for its DONE handshake, counts runs and raises a run interrupt.
module irst_ctrl
  import irst_ctrl_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr_en,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wr_data,
  output logic [15:0] cfg_rd_data,
  input  logic        irst_done,
  output logic [15:0] irst_reg_data,
  output logic        irq
);

  irst_cfg_t           cfg;
  logic [PERIOD_W-1:0] period;
  logic                start, abort;

  irst_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [6:0]          sh_pc_q, sh_pc_d;
  logic [5:0]          sh_mis_q, sh_mis_d;
  logic [7:0]          run_cnt_q, run_cnt_d;
  logic                abort_pend_q, abort_pend_d;
  logic                irq_q, irq_d;
  logic [15:0]         reg_q, reg_d;

  irst_regfile #(.PERIOD_W(PERIOD_W)) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en_i  (cfg_wr_en),
    .cfg_addr_i   (cfg_addr),
    .cfg_wr_data_i(cfg_wr_data),
    .cfg_rd_data_o(cfg_rd_data),
    .run_count_i  (run_cnt_q),
    .abort_pend_i (abort_pend_q),
    .state_i      (state_q),
    .cfg_o        (cfg),
    .period_o     (period),
    .start_o      (start),
    .abort_o      (abort)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sh_pc_q      <= '0;
      sh_mis_q     <= '0;
      run_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      irq_q        <= 1'b0;
      reg_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_pc_q      <= sh_pc_d;
      sh_mis_q     <= sh_mis_d;
      run_cnt_q    <= run_cnt_d;
      abort_pend_q <= abort_pend_d;
      irq_q        <= irq_d;
      reg_q        <= reg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_pc_d      = sh_pc_q;
    sh_mis_d     = sh_mis_q;
    run_cnt_d    = run_cnt_q;
    abort_pend_d = abort_pend_q;
    irq_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACTIVE;
          sh_pc_d  = cfg.pc_limit;
          sh_mis_d = cfg.mis_count;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_ACTIVE;
          sh_pc_d  = cfg.pc_limit;
          sh_mis_d = cfg.mis_count;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      ST_ACTIVE: begin
        // An abort cannot cut a run short; it only suppresses the next one.
        if (abort) abort_pend_d = 1'b1;
        if (irst_done) begin
          state_d   = ST_DRAIN;
          run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
          irq_d     = cfg.irq_en;
        end
      end
      ST_DRAIN: begin
        if (abort) abort_pend_d = 1'b1;
        if (!irst_done) begin
          abort_pend_d = 1'b0;
          if (!cfg.periodic || abort_pend_q || abort) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = period;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    reg_d = irst_pack(state_d == ST_ACTIVE, sh_pc_d, sh_mis_d);
  end

  assign irst_reg_data = reg_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_irst_ctrl.sv
// Directed + randomized bench for irst_ctrl; expectations come from the
// register map and run rules, with a simple run counter as the model.
module tb_irst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wr_data = 16'h0;
  logic [15:0] cfg_rd_data;
  logic        irst_done = 1'b0;
  logic [15:0] irst_reg_data;
  logic        irq;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;
  int runs   = 0;

  always #5 clk = ~clk;

  irst_ctrl #(.PERIOD_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_rd_data  (cfg_rd_data),
    .irst_done    (irst_done),
    .irst_reg_data(irst_reg_data),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rd_data;
  endtask

  function automatic int exp_rc();
    return (runs > 255) ? 255 : runs;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s, d, p;
    int c, lat, hold;

    // reset state
    #12;
    chk("rst_word", irst_reg_data, 0);
    chk("rst_irq", irq, 0);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], s);
      chk("rst_reg", s, 0);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // single run
    wr(2'd0, 16'h1405);
    wr(2'd2, 16'h0001);
    chk("single_en", irst_reg_data, 16'h9405);
    rd(2'd3, s); chk("single_active", s[1:0], 2);
    irst_done = 1'b1;
    @(negedge clk); runs++;
    chk("single_drain_word", irst_reg_data, 16'h1405);
    chk("single_irq_off", irq, 0);
    rd(2'd3, s); chk("single_status", s, 16'h0103);
    @(negedge clk);
    rd(2'd3, s); chk("drain_hold", s[1:0], 3);
    irst_done = 1'b0;
    @(negedge clk);
    rd(2'd3, s); chk("single_idle", s, 16'h0100);

    // periodic runs, then abort during WAIT
    wr(2'd1, 16'd3);
    wr(2'd0, 16'h0AC3);
    wr(2'd2, 16'h0001);
    chk("per_en", irst_reg_data, 16'h8A03);
    for (int r = 0; r < 3; r++) begin
      repeat (10) @(negedge clk);
      irst_done = 1'b1;
      @(negedge clk); runs++;
      chk("per_irq", irq, 1);
      chk("per_drain_en", irst_reg_data[15], 0);
      rd(2'd3, s); chk("per_rc", s[15:8], exp_rc());
      irst_done = 1'b0;
      @(negedge clk);
      chk("per_irq_1cyc", irq, 0);
      if (r < 2) begin
        c = 0;
        for (int k = 0; k < 50 && irst_reg_data[15] !== 1'b1; k++) begin
          rd(2'd3, s);
          if (s[1:0] == 2'd1) c++;
          @(negedge clk);
        end
        chk("per_wait_cycles", c, 4);
        chk("per_en_again", irst_reg_data, 16'h8A03);
      end else begin
        rd(2'd3, s); chk("per_in_wait", s[1:0], 1);
        wr(2'd2, 16'h0002);
        rd(2'd3, s); chk("abort_wait_idle", s[2:0], 0);
        c = 0;
        repeat (8) begin
          if (irst_reg_data[15] !== 1'b0) c++;
          @(negedge clk);
        end
        chk("abort_wait_no_en", c, 0);
      end
    end

    // abort during ACTIVE: run completes, then IDLE
    wr(2'd2, 16'h0001);
    chk("abort_act_en", irst_reg_data[15], 1);
    wr(2'd2, 16'h0002);
    chk("abort_act_en_held", irst_reg_data[15], 1);
    rd(2'd3, s); chk("abort_pend", s[2:0], 3'b110);
    irst_done = 1'b1;
    @(negedge clk); runs++;
    rd(2'd3, s); chk("abort_act_rc", s[15:8], exp_rc());
    irst_done = 1'b0;
    @(negedge clk);
    rd(2'd3, s); chk("abort_act_idle", s[2:0], 0);

    // shadowing and start during ACTIVE
    wr(2'd0, 16'h1405);
    wr(2'd2, 16'h0001);
    chk("shadow_first", irst_reg_data, 16'h9405);
    wr(2'd0, 16'h1409);
    chk("shadow_hold", irst_reg_data, 16'h9405);
    rd(2'd0, s); chk("shadow_cfg_rb", s, 16'h1409);
    wr(2'd2, 16'h0001);
    rd(2'd3, s); chk("start_in_active", s[1:0], 2);
    irst_done = 1'b1;
    @(negedge clk); runs++;
    chk("shadow_drain", irst_reg_data, 16'h1405);
    irst_done = 1'b0;
    @(negedge clk);
    rd(2'd3, s); chk("start_ignored_rc", s, {8'(exp_rc()), 8'h00});
    wr(2'd2, 16'h0001);
    chk("shadow_next", irst_reg_data, 16'h9409);
    irst_done = 1'b1;
    @(negedge clk); runs++;
    irst_done = 1'b0;
    @(negedge clk);

    // start+abort from IDLE is a no-op
    wr(2'd2, 16'h0003);
    rd(2'd3, s); chk("start_abort_idle", s[1:0], 0);
    chk("start_abort_no_en", irst_reg_data[15], 0);
    rd(2'd2, s); chk("cmd_reads_0", s, 0);

    // randomized single runs
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      d[6] = 1'b0;
      wr(2'd0, d);
      rd(2'd0, s); chk("rand_cfg_rb", s, d & 16'h7FFF);
      p = 16'($urandom);
      wr(2'd1, p);
      rd(2'd1, s); chk("rand_per_rb", s, p);
      wr(2'd2, 16'h0001);
      chk("rand_word", irst_reg_data, {1'b1, d[14:8], 2'b00, d[5:0]});
      lat = $urandom_range(0, 4);
      repeat (lat) @(negedge clk);
      irst_done = 1'b1;
      @(negedge clk); runs++;
      chk("rand_irq", irq, d[7]);
      chk("rand_drain_word", irst_reg_data, {1'b0, d[14:8], 2'b00, d[5:0]});
      rd(2'd3, s); chk("rand_rc", s[15:8], exp_rc());
      hold = $urandom_range(0, 2);
      repeat (hold) @(negedge clk);
      irst_done = 1'b0;
      @(negedge clk);
      rd(2'd3, s); chk("rand_idle", s[1:0], 0);
    end

    // run_count saturation
    while (runs < 260) begin
      wr(2'd2, 16'h0001);
      irst_done = 1'b1;
      @(negedge clk); runs++;
      irst_done = 1'b0;
      @(negedge clk);
    end
    rd(2'd3, s); chk("sat_rc", s[15:8], 255);
    chk("sat_state", s[1:0], 0);

    // asynchronous reset mid-ACTIVE
    wr(2'd0, 16'h12C7);
    wr(2'd2, 16'h0001);
    chk("rst_pre_en", irst_reg_data, 16'h9207);
    #2;
    rst = 1'b1;
    cfg_addr = 2'd3;
    #1;
    chk("arst_word", irst_reg_data, 0);
    chk("arst_status", cfg_rd_data, 0);
    chk("arst_irq", irq, 0);
    rd(2'd0, s); chk("arst_cfg", s, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    rd(2'd3, s); chk("post_rst_idle", s, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
